serial_subtractor_nbit: RTL and testbench

- Bit-serial N-bit subtractor computing a - b, LSB first, one bit per clock.
- Datapath is one 1-bit full-subtractor cell plus a registered borrow.
- Downstream consumer of the 1-bit subtraction cell: it chains that cell over time instead of in space.
- Parallel operands in, parallel difference and final borrow out, with a start/done handshake.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_subtractor_nbit_full_subtractor_1bit.sv | 26 ++
 rtl/serial_subtractor_nbit.sv | 128 ++++++++++++
 tb/tb_serial_subtractor_nbit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encodings and a constant clog2 used to size the bit counter.
package serial_sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Ceiling log2 for elaboration-time widths; returns at least 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_nbit_full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - b_in, with borrow out.
// Built from two half-subtraction stages and an OR of their borrows.
// Ports: a, b, b_in (inputs); d, b_out (combinational outputs).
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    logic d1_c;
    logic b1_c;
    logic b2_c;

    // First half-subtraction: a - b.
    assign d1_c  = a ^ b;
    assign b1_c  = ~a & b;

    // Second half-subtraction: (a - b) - b_in.
    assign d     = d1_c ^ b_in;
    assign b2_c  = ~d1_c & b_in;

    assign b_out = b1_c | b2_c;

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: computes a - b LSB first, one bit per clock,
// by reusing a single full-subtractor cell with a registered borrow.
// Ports: clk, rst_n (async active-low), start, a[N-1:0], b[N-1:0] in;
//        busy, done (1-cycle pulse), d[N-1:0], b_out (final borrow) out.
// Optional: define SERIAL_SUB_OVERFLOW_EN to add output ovf, the
//        two's-complement overflow of a - b.
module serial_subtractor_nbit
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic         ovf,
`endif
    output logic         b_out
);

    localparam int unsigned CNT_W = clog2(N);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [N-1:0]     a_sh_q;
    logic [N-1:0]     b_sh_q;
    logic [N-1:0]     res_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             di_c;
    logic             bnext_c;
    logic             last_c;

    full_subtractor_1bit u_fsub (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (borrow_q),
        .d     (di_c),
        .b_out (bnext_c)
    );

    assign last_c = (cnt_q == CNT_W'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:                state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Operand shift registers, result accumulator, borrow and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == IDLE && start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            res_q    <= {di_c, res_q[N-1:1]};
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            borrow_q <= bnext_c;
            // Hold at N-1 so the counter never wraps on the last bit.
            if (!last_c) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Registered handshake and result outputs; they follow state_q by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            b_out <= 1'b0;
        end else begin
            busy <= (state_q == RUN);
            done <= (state_q == DONE);
            if (state_q == DONE) begin
                d     <= res_q;
                b_out <= borrow_q;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;

    // Operand sign bits are kept because the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                a_msb_q <= a[N-1];
                b_msb_q <= b[N-1];
            end
            if (state_q == DONE) begin
                ovf <= (a_msb_q != b_msb_q) && (res_q[N-1] != a_msb_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit: directed N=4 vectors
// (latency, busy width, borrow, restart-ignore, mid-run reset, back-to-back)
// plus an N=8 random regression against a behavioural a-b model.
module tb_serial_subtractor_nbit;

    logic       clk;
    logic       rst_n;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] d4;
    logic       bo4;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bo8;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ovf4;
    logic       ovf8;
`endif

    int n_cmp;
    int n_bad;

    serial_subtractor_nbit #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .d     (d4),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf   (ovf4),
`endif
        .b_out (bo4)
    );

    serial_subtractor_nbit #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .ovf   (ovf8),
`endif
        .b_out (bo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One N=4 operation: pulse start, then track busy/done until done, bounded.
    task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] exp_d, input logic exp_bo, input logic exp_ovf);
        int busy_cnt;
        int lat;
        bit seen;
        busy_cnt = 0;
        lat = 0;
        seen = 1'b0;
        @(negedge clk);
        a4 = av; b4 = bv; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~av; b4 = ~bv;            // operands may change after capture
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (busy4) busy_cnt++;
            if (done4) begin
                seen = 1'b1;
                lat = c;
            end
        end
        check_val({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_val({tag, " latency"}, 32'(lat), 32'd5);
            check_val({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
            check_val({tag, " busy_in_done"}, 32'(busy4), 32'd0);
            check_val({tag, " d"}, 32'(d4), 32'(exp_d));
            check_val({tag, " b_out"}, 32'(bo4), 32'(exp_bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
            check_val({tag, " ovf"}, 32'(ovf4), 32'(exp_ovf));
`else
            if (exp_ovf) begin end
`endif
            @(negedge clk);
            check_val({tag, " done_one_cycle"}, 32'(done4), 32'd0);
            check_val({tag, " d_held"}, 32'(d4), 32'(exp_d));
        end
    endtask

    // One N=8 operation checked against the behavioural model.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] exp_d;
        logic       exp_ovf;
        bit seen;
        exp_d   = 8'(av - bv);
        exp_ovf = (av[7] != bv[7]) && (exp_d[7] != av[7]);
        seen = 1'b0;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check_val("n8 done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_val("n8 d", 32'(d8), 32'(exp_d));
            check_val("n8 b_out", 32'(bo8), 32'(av < bv));
`ifdef SERIAL_SUB_OVERFLOW_EN
            check_val("n8 ovf", 32'(ovf8), 32'(exp_ovf));
`else
            if (exp_ovf) begin end
`endif
        end
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check_val("reset busy", 32'(busy4), 32'd0);
        check_val("reset done", 32'(done4), 32'd0);
        check_val("reset d", 32'(d4), 32'd0);
        check_val("reset b_out", 32'(bo4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: tag, a, b, d, b_out, ovf (all hand-computed).
        op4("9-3",   4'd9,  4'd3,  4'd6,  1'b0, 1'b1);
        op4("3-9",   4'd3,  4'd9,  4'd10, 1'b1, 1'b1);
        op4("7-8",   4'd7,  4'd8,  4'd15, 1'b1, 1'b1);
        op4("0-0",   4'd0,  4'd0,  4'd0,  1'b0, 1'b0);
        op4("15-15", 4'd15, 4'd15, 4'd0,  1'b0, 1'b0);
        op4("0-1",   4'd0,  4'd1,  4'd15, 1'b1, 1'b0);

        // Restart while running is ignored: 12-5 must complete with one done.
        dones = 0;
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd5; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        check_val("restart done_count", 32'(dones), 32'd1);
        check_val("restart d", 32'(d4), 32'd7);
        check_val("restart b_out", 32'(bo4), 32'd0);

        // Reset during the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        a4 = 4'd10; b4 = 4'd3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check_val("prerst busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst busy", 32'(busy4), 32'd0);
        check_val("rst done", 32'(done4), 32'd0);
        check_val("rst d", 32'(d4), 32'd0);
        check_val("rst b_out", 32'(bo4), 32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        check_val("rst no_done", 32'(dones), 32'd0);
        rst_n = 1'b1;
        op4("10-3", 4'd10, 4'd3, 4'd7, 1'b0, 1'b1);

        // Start held high: consecutive done pulses are N+2 = 6 cycles apart.
        first_done = -1;
        second_done = -1;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd2; start4 = 1'b1;
        for (int c = 0; c < 30 && second_done < 0; c++) begin
            @(negedge clk);
            if (done4) begin
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
        end
        start4 = 1'b0;
        check_val("b2b spacing", 32'(second_done - first_done), 32'd6);
        check_val("b2b d", 32'(d4), 32'd3);
        repeat (10) @(negedge clk);

        // N=8 regression.
        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom));
        end
        op8(8'h00, 8'hFF);
        op8(8'hFF, 8'h00);
        op8(8'h80, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
